// File: rtl/ram_traffic_gen.sv
// RAM traffic generator: write burst with a linear data pattern, optional idle gap,
// then a read burst whose returned data is checked through an RD_LAT-deep pipeline.
//
// state   | meaning
// IDLE    | waiting for start
// WRITE   | one write beat per cycle
// GAP     | IDLE_GAP cycles with no strobes
// READ    | one read beat per cycle
// DRAIN   | RD_LAT cycles retiring outstanding compares
// DONE    | one-cycle done pulse
module ram_traffic_gen #(
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 32,
    parameter int                BURST_LEN = 24,
    parameter logic [ADDR_W-1:0] STRIDE    = 4,
    parameter logic [ADDR_W-1:0] WR_BASE   = 0,
    parameter logic [ADDR_W-1:0] RD_BASE   = 512,
    parameter logic [DATA_W-1:0] DATA_SEED = 0,
    parameter logic [DATA_W-1:0] DATA_INC  = 4,
    parameter int                IDLE_GAP  = 5,
    parameter int                RD_LAT    = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    output logic              write,
    output logic              read,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_count
);

    localparam int BEAT_W  = $clog2(BURST_LEN + 1);
    localparam int TMR_MAX = (IDLE_GAP > RD_LAT) ? IDLE_GAP : RD_LAT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [DATA_W-1:0]   pat_q, pat_d;
    logic [1:0]          mode_q, mode_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                write_q, write_d, read_q, read_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [15:0]         err_q, err_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic [DATA_W-1:0]   cmp_q [RD_LAT];
    logic [DATA_W-1:0]   cmp_d [RD_LAT];
    logic                go_read, rd_from_base;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        tmr_d        = tmr_q;
        pat_d        = pat_q;
        mode_d       = mode_q;
        address_d    = address_q;
        data_out_d   = data_out_q;
        write_d      = 1'b0;
        read_d       = 1'b0;
        done_d       = 1'b0;
        err_d        = err_q;
        go_read      = 1'b0;
        rd_from_base = 1'b0;

        // Expected word of the current read beat enters the compare pipeline.
        vld_d[0] = (state_q == S_READ) && mode_q[1];
        cmp_d[0] = pat_q;
        for (int k = 1; k < RD_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            cmp_d[k] = cmp_q[k-1];
        end
        if (vld_q[RD_LAT-1] && (data_in != cmp_q[RD_LAT-1]) && (err_q != 16'hFFFF))
            err_d = err_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d  = '0;
                    mode_d = mode;
                    if (mode == 2'd1) begin
                        go_read      = 1'b1;
                        rd_from_base = 1'b1;
                    end else begin
                        state_d    = S_WRITE;
                        beat_d     = '0;
                        pat_d      = DATA_SEED;
                        write_d    = 1'b1;
                        address_d  = WR_BASE;
                        data_out_d = DATA_SEED;
                    end
                end
            end
            S_WRITE: begin
                if (beat_q == LAST_BEAT) begin
                    if (mode_q == 2'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (IDLE_GAP > 0) begin
                        state_d = S_GAP;
                        tmr_d   = TMR_W'(IDLE_GAP - 1);
                    end else begin
                        go_read = 1'b1;
                    end
                end else begin
                    beat_d     = beat_q + BEAT_W'(1);
                    pat_d      = pat_q + DATA_INC;
                    address_d  = address_q + STRIDE;
                    data_out_d = pat_q + DATA_INC;
                    write_d    = 1'b1;
                end
            end
            S_GAP: begin
                if (tmr_q == '0) go_read = 1'b1;
                else             tmr_d   = tmr_q - TMR_W'(1);
            end
            S_READ: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = S_DRAIN;
                    tmr_d   = TMR_W'(RD_LAT - 1);
                end else begin
                    beat_d    = beat_q + BEAT_W'(1);
                    pat_d     = pat_q + DATA_INC;
                    address_d = address_q + STRIDE;
                    read_d    = 1'b1;
                end
            end
            S_DRAIN: begin
                if (tmr_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (go_read) begin
            state_d    = S_READ;
            beat_d     = '0;
            pat_d      = DATA_SEED;
            read_d     = 1'b1;
            data_out_d = '0;
            address_d  = rd_from_base ? RD_BASE : WR_BASE;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            tmr_q      <= '0;
            pat_q      <= '0;
            mode_q     <= '0;
            address_q  <= '0;
            data_out_q <= '0;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= '0;
            vld_q      <= '0;
            for (int k = 0; k < RD_LAT; k++) cmp_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            tmr_q      <= tmr_d;
            pat_q      <= pat_d;
            mode_q     <= mode_d;
            address_q  <= address_d;
            data_out_q <= data_out_d;
            write_q    <= write_d;
            read_q     <= read_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            vld_q      <= vld_d;
            for (int k = 0; k < RD_LAT; k++) cmp_q[k] <= cmp_d[k];
        end
    end

    assign address   = address_q;
    assign data_out  = data_out_q;
    assign write     = write_q;
    assign read      = read_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_q;

endmodule
